// File: rtl/adc_sample_averager.sv
// Averages windows of 2**LOG2_N thermometer-validated ADC codes and holds the result
// until a consumer accepts it. Invalid codes are counted, and dropped results set a sticky flag.
module adc_sample_averager #(
  parameter int LOG2_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sample_en,
  input  logic [3:0]        thermo_in,
  input  logic [1:0]        code_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        avg_out,
  output logic [LOG2_N+1:0] sum_out,
  output logic [3:0]        err_count,
  output logic              overrun
);

  localparam int unsigned SW = LOG2_N + 2;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [SW-1:0]     acc_q, acc_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic [3:0]        err_q, err_d;
  logic              ovr_q, ovr_d;

  logic              thermo_ok;
  logic              active;
  logic              accept;
  logic              reject;
  logic              complete;
  logic [SW-1:0]     win_sum;

  always_comb begin
    thermo_ok = thermo_in inside {4'b0001, 4'b0011, 4'b0111, 4'b1111};
    active    = (state_q == ACCUM) && enable;
    accept    = active && sample_en && thermo_ok;
    reject    = active && sample_en && !thermo_ok;
    complete  = accept && (cnt_q == '1);
    win_sum   = acc_q + SW'(code_in);

    state_d = enable ? ACCUM : IDLE;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    err_d   = err_q;
    ovr_d   = ovr_q;

    // Leaving ACCUM (or sitting in IDLE) discards any partial window.
    if (!active) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + LOG2_N'(1);
      acc_d = complete ? '0 : win_sum;
    end

    if (reject && (err_q != 4'hF)) begin
      err_d = err_q + 4'd1;
    end

    // A completed window only replaces the result when the slot is free or being drained.
    if (complete && (!valid_q || out_ready)) begin
      sum_d   = win_sum;
      valid_d = 1'b1;
    end else if (complete) begin
      ovr_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      err_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_valid = valid_q;
  assign sum_out   = sum_q;
  assign avg_out   = sum_q[LOG2_N +: 2];
  assign err_count = err_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Self-checking bench for adc_sample_averager: directed scenarios plus random traffic,
// all compared against a window-queue reference model.
module tb_adc_sample_averager;

  localparam int LOG2_N = 2;
  localparam int N      = 1 << LOG2_N;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              sample_en;
  logic [3:0]        thermo_in;
  logic [1:0]        code_in;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        avg_out;
  logic [LOG2_N+1:0] sum_out;
  logic [3:0]        err_count;
  logic              overrun;

  int checks   = 0;
  int failures = 0;

  // Reference model state: the accepted codes of the open window, the held result and flags.
  bit m_accum;
  int win[$];
  bit m_valid;
  int m_sum;
  int m_err;
  bit m_ovr;

  adc_sample_averager #(.LOG2_N(LOG2_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .sample_en (sample_en),
    .thermo_in (thermo_in),
    .code_in   (code_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .avg_out   (avg_out),
    .sum_out   (sum_out),
    .err_count (err_count),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit is_thermo(input logic [3:0] t);
    return (t == 4'b0001) || (t == 4'b0011) || (t == 4'b0111) || (t == 4'b1111);
  endfunction

  task automatic model_edge();
    bit done;
    int s;
    done = 1'b0;
    s    = 0;
    if (rst) begin
      m_accum = 1'b0;
      win.delete();
      m_valid = 1'b0;
      m_sum   = 0;
      m_err   = 0;
      m_ovr   = 1'b0;
    end else begin
      if (m_accum && enable && sample_en) begin
        if (is_thermo(thermo_in)) begin
          win.push_back(int'(code_in));
          if (win.size() == N) begin
            foreach (win[i]) s += win[i];
            win.delete();
            done = 1'b1;
          end
        end else if (m_err < 15) begin
          m_err++;
        end
      end
      if (done && (!m_valid || out_ready)) begin
        m_sum   = s;
        m_valid = 1'b1;
      end else if (done) begin
        m_ovr = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (!enable) win.delete();
      m_accum = enable;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid",   int'(out_valid), int'(m_valid));
    chk("sum",     int'(sum_out),   m_sum);
    chk("avg",     int'(avg_out),   m_sum >> LOG2_N);
    chk("err",     int'(err_count), m_err);
    chk("overrun", int'(overrun),   int'(m_ovr));
  endtask

  task automatic smp(input logic [3:0] t, input logic [1:0] c);
    sample_en = 1'b1;
    thermo_in = t;
    code_in   = c;
    step();
    sample_en = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    sample_en = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    sample_en = 1'b0;
    thermo_in = 4'b0000;
    code_in   = 2'd0;
    out_ready = 1'b1;

    do_reset();
    chk("rst_valid",   int'(out_valid), 0);
    chk("rst_sum",     int'(sum_out),   0);
    chk("rst_avg",     int'(avg_out),   0);
    chk("rst_err",     int'(err_count), 0);
    chk("rst_overrun", int'(overrun),   0);

    // Basic window: 3+3+2+1
    out_ready = 1'b1;
    enable    = 1'b1;
    step();
    smp(4'b1111, 2'd3);
    smp(4'b1111, 2'd3);
    smp(4'b0111, 2'd2);
    smp(4'b0011, 2'd1);
    chk("basic_valid", int'(out_valid), 1);
    chk("basic_sum",   int'(sum_out),   9);
    chk("basic_avg",   int'(avg_out),   2);

    // Rejected codes interleaved with valid ones
    do_reset();
    enable = 1'b1;
    step();
    smp(4'b0001, 2'd1);
    smp(4'b0101, 2'd0);
    smp(4'b0001, 2'd1);
    smp(4'b1000, 2'd2);
    smp(4'b0001, 2'd1);
    smp(4'b0001, 2'd1);
    chk("rej_err", int'(err_count), 2);
    chk("rej_sum", int'(sum_out),   4);
    chk("rej_avg", int'(avg_out),   1);

    // Overrun: second result dropped while first is held
    do_reset();
    out_ready = 1'b0;
    enable    = 1'b1;
    step();
    repeat (4) smp(4'b0001, 2'd1);
    repeat (4) smp(4'b1111, 2'd3);
    chk("ovr_sum",     int'(sum_out),   4);
    chk("ovr_flag",    int'(overrun),   1);
    chk("ovr_valid",   int'(out_valid), 1);
    out_ready = 1'b1;
    step();
    chk("ovr_drained", int'(out_valid), 0);
    chk("ovr_sticky",  int'(overrun),   1);

    // Partial window discarded by enable low
    do_reset();
    out_ready = 1'b1;
    enable    = 1'b1;
    step();
    smp(4'b1111, 2'd3);
    smp(4'b1111, 2'd3);
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
    repeat (4) smp(4'b1111, 2'd3);
    chk("part_sum", int'(sum_out), 12);
    chk("part_avg", int'(avg_out), 3);

    // Reset mid-window with a result pending
    do_reset();
    out_ready = 1'b0;
    enable    = 1'b1;
    step();
    repeat (4) smp(4'b0001, 2'd1);
    repeat (3) smp(4'b0011, 2'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_sum",   int'(sum_out),   0);
    chk("mid_rst_ovr",   int'(overrun),   0);
    step();
    repeat (4) smp(4'b0011, 2'd2);
    chk("post_rst_sum", int'(sum_out), 8);
    chk("post_rst_avg", int'(avg_out), 2);

    // Error counter saturation
    do_reset();
    enable = 1'b1;
    step();
    repeat (20) smp(4'b0101, 2'd0);
    chk("err_sat", int'(err_count), 15);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int unsigned pick;
      rst       = ($urandom % 150) == 0;
      enable    = ($urandom % 16) != 0;
      sample_en = enable && ($urandom % 2 == 0);
      out_ready = ($urandom % 3) != 0;
      if ($urandom % 4 != 0) begin
        pick      = $urandom % 4;
        thermo_in = 4'((1 << (pick + 1)) - 1);
        code_in   = 2'(pick);
      end else begin
        thermo_in = 4'($urandom);
        code_in   = 2'($urandom);
      end
      step();
    end
    rst       = 1'b0;
    sample_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
